// File: rtl/multdiv_issue_ctrl_pkg.sv
// Shared types and default constants for the mul/div issue controller.
// MD_WATCHDOG_EN enables a BUSY-state watchdog that forces an exception writeback.
package multdiv_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } md_state_e;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } md_op_e;

    localparam int unsigned MD_WIDTH          = 32;
    localparam int unsigned MD_REG_ADDR_W     = 5;
    localparam int unsigned MD_RSTATUS_REG    = 30;
    localparam int unsigned MD_MULT_EXC_CODE  = 4;
    localparam int unsigned MD_DIV_EXC_CODE   = 5;
    localparam int unsigned MD_TIMEOUT_CYCLES = 40;

    // Multiply wins when the decoder raises both requests.
    function automatic md_op_e sel_op(input logic start_mult);
        return start_mult ? OP_MULT : OP_DIV;
    endfunction

endpackage

// File: rtl/multdiv_issue_ctrl_if.sv
// Bundle of X-stage request, multdiv handshake and writeback signals.
// master = the issue controller, slave = the surrounding pipeline/multdiv.
interface multdiv_issue_ctrl_if
    import multdiv_issue_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH      = MD_WIDTH,
    parameter int unsigned REG_ADDR_W = MD_REG_ADDR_W
);
    logic                  start_mult;
    logic                  start_div;
    logic                  flush;
    logic [WIDTH-1:0]      opA;
    logic [WIDTH-1:0]      opB;
    logic [REG_ADDR_W-1:0] rd;
    logic [WIDTH-1:0]      md_operandA;
    logic [WIDTH-1:0]      md_operandB;
    logic                  ctrl_MULT;
    logic                  ctrl_DIV;
    logic [WIDTH-1:0]      data_result;
    logic                  data_exception;
    logic                  data_resultRDY;
    logic                  stall;
    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [WIDTH-1:0]      wb_data;
    logic                  wb_exception;

    modport master (
        input  start_mult, start_div, flush, opA, opB, rd,
        input  data_result, data_exception, data_resultRDY,
        output md_operandA, md_operandB, ctrl_MULT, ctrl_DIV,
        output stall, wb_valid, wb_rd, wb_data, wb_exception
    );

    modport slave (
        output start_mult, start_div, flush, opA, opB, rd,
        output data_result, data_exception, data_resultRDY,
        input  md_operandA, md_operandB, ctrl_MULT, ctrl_DIV,
        input  stall, wb_valid, wb_rd, wb_data, wb_exception
    );

endinterface

// File: rtl/multdiv_issue_ctrl_md_operand_latch.sv
// Holds operands, destination register and op type of the accepted request
// so the multdiv sees stable inputs for the whole operation.
module multdiv_issue_ctrl_md_operand_latch
    import multdiv_issue_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH      = MD_WIDTH,
    parameter int unsigned REG_ADDR_W = MD_REG_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic [WIDTH-1:0]      op_a_i,
    input  logic [WIDTH-1:0]      op_b_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  md_op_e                op_i,
    output logic [WIDTH-1:0]      op_a_o,
    output logic [WIDTH-1:0]      op_b_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output md_op_e                op_o
);
    logic [WIDTH-1:0]      op_a_q, op_a_d;
    logic [WIDTH-1:0]      op_b_q, op_b_d;
    logic [REG_ADDR_W-1:0] rd_q,   rd_d;
    md_op_e                op_q,   op_d;

    always_comb begin
        // NOTE: hold-value defaults first so no path leaves a signal unassigned (no latch).
        op_a_d = op_a_q;
        op_b_d = op_b_q;
        rd_d   = rd_q;
        op_d   = op_q;
        if (en) begin
            op_a_d = op_a_i;
            op_b_d = op_b_i;
            rd_d   = rd_i;
            op_d   = op_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_a_q <= '0;
            op_b_q <= '0;
            rd_q   <= '0;
            op_q   <= OP_MULT;
        end else begin
            op_a_q <= op_a_d;
            op_b_q <= op_b_d;
            rd_q   <= rd_d;
            op_q   <= op_d;
        end
    end

    assign op_a_o = op_a_q;
    assign op_b_o = op_b_q;
    assign rd_o   = rd_q;
    assign op_o   = op_q;

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Execute-stage issue/stall controller for the multiplier and divider.
// Optional MD_WATCHDOG_EN: BUSY timeout after TIMEOUT_CYCLES yields an exception packet.
module multdiv_issue_ctrl
    import multdiv_issue_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH         = MD_WIDTH,
    parameter int unsigned REG_ADDR_W    = MD_REG_ADDR_W,
    parameter int unsigned RSTATUS_REG   = MD_RSTATUS_REG,
    parameter int unsigned MULT_EXC_CODE = MD_MULT_EXC_CODE,
    parameter int unsigned DIV_EXC_CODE  = MD_DIV_EXC_CODE
`ifdef MD_WATCHDOG_EN
    ,parameter int unsigned TIMEOUT_CYCLES = MD_TIMEOUT_CYCLES
`endif
) (
    input  logic                  clock,
    input  logic                  reset,
    multdiv_issue_ctrl_if.master  md
);
    md_state_e             state_q, state_d;
    logic                  accept;
    logic                  capture;
    logic                  capture_exc;
    logic [WIDTH-1:0]      op_a_q, op_b_q;
    logic [REG_ADDR_W-1:0] rd_q;
    md_op_e                op_q;
    logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic [WIDTH-1:0]      wb_data_q, wb_data_d;
    logic                  wb_exc_q, wb_exc_d;
    logic [WIDTH-1:0]      exc_code;

    multdiv_issue_ctrl_md_operand_latch #(
        .WIDTH      (WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_latch (
        .clock  (clock),
        .reset  (reset),
        .en     (accept),
        .op_a_i (md.opA),
        .op_b_i (md.opB),
        .rd_i   (md.rd),
        .op_i   (sel_op(md.start_mult)),
        .op_a_o (op_a_q),
        .op_b_o (op_b_q),
        .rd_o   (rd_q),
        .op_o   (op_q)
    );

    assign exc_code = (op_q == OP_MULT) ? WIDTH'(MULT_EXC_CODE) : WIDTH'(DIV_EXC_CODE);

`ifdef MD_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            wd_expired;

    // Counter value equals BUSY cycles already spent; expiry on the last allowed one.
    assign wd_expired = (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == ST_START)     wd_cnt_d = '0;
        else if (state_q == ST_BUSY) wd_cnt_d = wd_cnt_q + WD_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) wd_cnt_q <= '0;
        else       wd_cnt_q <= wd_cnt_d;
    end
`endif

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        capture     = 1'b0;
        capture_exc = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        wb_exc_d    = wb_exc_q;
        unique case (state_q)
            ST_IDLE: begin
                if ((md.start_mult || md.start_div) && !md.flush) begin
                    accept  = 1'b1;
                    state_d = ST_START;
                end
            end
            // resultRDY seen here still belongs to the previous operation.
            ST_START: state_d = md.flush ? ST_IDLE : ST_BUSY;
            ST_BUSY: begin
                if (md.flush) begin
                    state_d = ST_IDLE;
                end else if (md.data_resultRDY) begin
                    capture     = 1'b1;
                    capture_exc = md.data_exception;
`ifdef MD_WATCHDOG_EN
                end else if (wd_expired) begin
                    capture     = 1'b1;
                    capture_exc = 1'b1;
`endif
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (capture) begin
            state_d   = ST_DONE;
            wb_exc_d  = capture_exc;
            wb_rd_d   = capture_exc ? REG_ADDR_W'(RSTATUS_REG) : rd_q;
            wb_data_d = capture_exc ? exc_code : md.data_result;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            wb_exc_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            wb_exc_q  <= wb_exc_d;
        end
    end

    assign md.md_operandA  = op_a_q;
    assign md.md_operandB  = op_b_q;
    assign md.ctrl_MULT    = (state_q == ST_START) && (op_q == OP_MULT);
    assign md.ctrl_DIV     = (state_q == ST_START) && (op_q == OP_DIV);
    assign md.stall        = accept || (state_q == ST_START) || (state_q == ST_BUSY);
    assign md.wb_valid     = (state_q == ST_DONE);
    assign md.wb_rd        = (state_q == ST_DONE) ? wb_rd_q   : '0;
    assign md.wb_data      = (state_q == ST_DONE) ? wb_data_q : '0;
    assign md.wb_exception = (state_q == ST_DONE) && wb_exc_q;

endmodule

// File: doc/multdiv_issue_ctrl.md
Name: multdiv_issue_ctrl

Overview:
- Execute-stage issue/stall controller sitting directly upstream of the multiplier and divider.
- Accepts a decoded mul/div request and latches its operands and destination register.
- Fires a single-cycle ctrl_MULT/ctrl_DIV pulse, then holds operands stable and stalls the pipeline until data_resultRDY.
- Captures the result or exception into a one-cycle writeback packet (result to rd, or exception code to $rstatus/r30).

Parameters:
- WIDTH, 32, operand/result width.
- REG_ADDR_W, 5, register address width.
- RSTATUS_REG, 30, destination register on exception.
- MULT_EXC_CODE, 4, value written to $rstatus on mult overflow.
- DIV_EXC_CODE, 5, value written to $rstatus on divide exception.
- TIMEOUT_CYCLES, 40, watchdog limit (used only with MD_WATCHDOG_EN).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start_mult  in  1  X-stage holds a mul instruction.
- start_div  in  1  X-stage holds a div instruction.
- flush  in  1  squash in-flight op (branch/jump redirect).
- opA  in  WIDTH  rs value from bypass.
- opB  in  WIDTH  rt value from bypass.
- rd  in  REG_ADDR_W  destination register.
- md_operandA  out  WIDTH  latched operand A to multdiv.
- md_operandB  out  WIDTH  latched operand B to multdiv.
- ctrl_MULT  out  1  one-cycle start pulse, multiplier.
- ctrl_DIV  out  1  one-cycle start pulse, divider.
- data_result  in  WIDTH  multdiv result.
- data_exception  in  1  multdiv exception flag.
- data_resultRDY  in  1  multdiv done.
- stall  out  1  freeze PC/F/D/X latches.
- wb_valid  out  1  writeback packet valid (one cycle).
- wb_rd  out  REG_ADDR_W  writeback register.
- wb_data  out  WIDTH  writeback value.
- wb_exception  out  1  packet is an exception write.

Behaviour:
- Interface fixed: single clock "clock"; reset "reset" is asynchronous, active-high.
- Reset: state=IDLE. All outputs 0: md_operandA/B, ctrl_*, stall, wb_*.
- States: IDLE, START, BUSY, DONE.
- IDLE:
  - On start_mult|start_div with !flush: latch opA, opB, rd and op type (mult has priority if both asserted); go to START.
  - stall is combinationally 1 in the accept cycle.
- START (1 cycle): ctrl_MULT or ctrl_DIV=1 per op type; stall=1; data_resultRDY ignored (stale from previous op); go to BUSY.
- BUSY:
  - stall=1; md_operandA/B held constant.
  - On data_resultRDY: capture result/exception; go to DONE.
- DONE (1 cycle):
  - wb_valid=1, stall=0; go to IDLE.
  - Normal completion: wb_rd=latched rd, wb_data=data_result, wb_exception=0.
  - Exception: wb_rd=RSTATUS_REG, wb_data=MULT_EXC_CODE or DIV_EXC_CODE (zero-extended), wb_exception=1.
  - A new start seen in DONE is not accepted; it is accepted next cycle in IDLE.
- Minimum request-to-writeback: accept edge, START, >=1 BUSY, DONE. Mult (34 cycles) completes well inside.
- flush in START or BUSY: go to IDLE, no wb_valid, stall=0 next cycle. ctrl_* already pulsed is not retracted; the late resultRDY is ignored in IDLE.
- flush in DONE: writeback still occurs (instruction already committed).
- rd=0: packet still issued; regfile discards.
- reset mid-operation: immediate return to IDLE; all outputs 0; no writeback.
- ctrl_MULT and ctrl_DIV are never simultaneously 1 and never high for more than one cycle.

Optional Feature:
- Macro MD_WATCHDOG_EN.
- Defined:
  - Counter cleared in START, increments each BUSY cycle.
  - On reaching TIMEOUT_CYCLES without data_resultRDY: go to DONE with an exception packet (wb_rd=RSTATUS_REG, wb_data=op's exception code).
  - data_resultRDY in the same cycle as timeout wins (normal capture).
- Undefined: no counter; BUSY waits indefinitely.

Decomposition:
- Shared package: state enum (IDLE/START/BUSY/DONE), op-type constants (OP_MULT, OP_DIV), RSTATUS_REG, exception codes.
- One sub-module natural: md_operand_latch, holding opA/opB/rd/op type with enable on accept and async clear.

Test Plan:
- mult 7*(-3), rd=5 -> ctrl_MULT high exactly 1 cycle after accept; stall high until DONE; wb_valid 1 cycle, wb_rd=5, wb_data=32'hFFFFFFEB, wb_exception=0.
- mult 32'h7FFFFFFF*2 with data_exception=1, rd=8 -> wb_rd=30, wb_data=4, wb_exception=1.
- div 100/0 with exception, rd=3 -> ctrl_DIV pulsed once; wb_rd=30, wb_data=5.
- flush 10 cycles into BUSY -> stall drops next cycle, no wb_valid; later resultRDY ignored; a following mult 2*3 gives wb_data=6.
- reset asserted mid-BUSY -> all outputs 0 asynchronously, state IDLE, no writeback after release.
- start_mult and start_div together, plus stale resultRDY=1 during START -> only ctrl_MULT pulses, no early DONE; with MD_WATCHDOG_EN and resultRDY held 0, exception packet after TIMEOUT_CYCLES BUSY cycles.
